// File: rtl/execute_cycle_if.sv
// ---------------------------------------------------------------------------
// execute_cycle_if
//   Bundle of every non-clock signal of the RV32IM execute stage.
//   slave  : the execute stage itself. It consumes the ID/EX register fields,
//            the forwarding selects, ResultW and FlushE. It produces the
//            EX/MEM register, the branch redirect (PCSrcE/PCTargetE) and the
//            front-end stall (StallE).
//   master : whatever surrounds the stage (pipeline top or a testbench).
// ---------------------------------------------------------------------------
interface execute_cycle_if #(
  parameter int XLEN = 32
);
  // ID/EX register fields
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RDE;
  logic [2:0]      RegWriteE;
  logic [1:0]      MemWriteE;
  logic [1:0]      ResultSrcE;
  logic [3:0]      ALUControlE;
  logic            ALUSrcE;
  logic [2:0]      Funct3E;
  logic            MulDivE;
  logic            BranchE;
  logic            JumpE;
  logic            JalrE;

  // hazard unit / writeback
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;
  logic            FlushE;

  // EX/MEM register
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;
  logic [4:0]      RDM;
  logic [2:0]      RegWriteM;
  logic [1:0]      MemWriteM;
  logic [1:0]      ResultSrcM;

  // redirect and stall
  logic [XLEN-1:0] PCTargetE;
  logic            PCSrcE;
  logic            StallE;

  modport master (
    output RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE, RegWriteE, MemWriteE,
           ResultSrcE, ALUControlE, ALUSrcE, Funct3E, MulDivE, BranchE,
           JumpE, JalrE, ForwardAE, ForwardBE, ResultW, FlushE,
    input  ALUResultM, WriteDataM, PCPlus4M, RDM, RegWriteM, MemWriteM,
           ResultSrcM, PCTargetE, PCSrcE, StallE
  );

  modport slave (
    input  RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RDE, RegWriteE, MemWriteE,
           ResultSrcE, ALUControlE, ALUSrcE, Funct3E, MulDivE, BranchE,
           JumpE, JalrE, ForwardAE, ForwardBE, ResultW, FlushE,
    output ALUResultM, WriteDataM, PCPlus4M, RDM, RegWriteM, MemWriteM,
           ResultSrcM, PCTargetE, PCSrcE, StallE
  );
endinterface

// File: rtl/execute_cycle.sv
// ---------------------------------------------------------------------------
// execute_cycle
//   RV32IM execute stage. It performs operand forwarding, the integer ALU,
//   a single-cycle MUL/MULH/MULHSU/MULHU and an iterative restoring
//   DIV/DIVU/REM/REMU. It resolves branches and jumps and owns the EX/MEM
//   pipeline register.
//
//   Ports
//     clk  : clock, all state updates on the rising edge
//     rst  : synchronous, active-high reset
//     bus  : execute_cycle_if.slave
//       in  : ID/EX fields, ForwardAE/BE, ResultW, FlushE
//       out : EX/MEM register, PCTargetE/PCSrcE (combinational), StallE
//
//   Divide timing: the op is accepted in cycle 0. The stage then runs 32
//   iteration cycles and commits from the DONE state at the end of cycle 33.
//   StallE is high in cycles 0..32. A zero divisor and signed overflow skip
//   the iterations and commit one cycle after acceptance.
// ---------------------------------------------------------------------------
module execute_cycle #(
  parameter int XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  execute_cycle_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // EX/MEM register
  logic [XLEN-1:0] alu_result_m_reg;
  logic [XLEN-1:0] write_data_m_reg;
  logic [XLEN-1:0] pc_plus4_m_reg;
  logic [4:0]      rd_m_reg;
  logic [2:0]      reg_write_m_reg;
  logic [1:0]      mem_write_m_reg;
  logic [1:0]      result_src_m_reg;

  // operand forwarding: index 0 is SrcA, index 1 is the pre-ALUSrc SrcB
  logic [XLEN-1:0] rd_op  [2];
  logic [1:0]      fwd_sel[2];
  logic [XLEN-1:0] fwd_op [2];

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;

  assign rd_op[0]   = bus.RD1E;
  assign rd_op[1]   = bus.RD2E;
  assign fwd_sel[0] = bus.ForwardAE;
  assign fwd_sel[1] = bus.ForwardBE;

  // Select 2'b11 behaves like 2'b00.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    assign fwd_op[gi] = (fwd_sel[gi] == 2'b01) ? bus.ResultW :
                        (fwd_sel[gi] == 2'b10) ? alu_result_m_reg :
                                                 rd_op[gi];
  end

  assign src_a = fwd_op[0];
  assign fwd_b = fwd_op[1];
  assign src_b = bus.ALUSrcE ? bus.ImmExtE : fwd_b;

  // ---------------------------------------------------------------- ALU
  logic [XLEN-1:0] alu_result;

  always_comb begin
    alu_result = src_a + src_b;
    case (bus.ALUControlE)
      4'h0:    alu_result = src_a + src_b;
      4'h1:    alu_result = src_a - src_b;
      4'h2:    alu_result = src_a & src_b;
      4'h3:    alu_result = src_a | src_b;
      4'h4:    alu_result = src_a ^ src_b;
      4'h5:    alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      4'h6:    alu_result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      4'h7:    alu_result = src_a << src_b[4:0];
      4'h8:    alu_result = src_a >> src_b[4:0];
      4'h9:    alu_result = $unsigned($signed(src_a) >>> src_b[4:0]);
      4'hA:    alu_result = src_b;
      default: alu_result = src_a + src_b;
    endcase
  end

  // ---------------------------------------------------------- multiplier
  // Each operand is extended to 2*XLEN bits as signed or unsigned. The low
  // 2*XLEN bits of the product are then correct for every MUL* flavour.
  logic              mul_a_signed;
  logic              mul_b_signed;
  logic [2*XLEN-1:0] mul_a_ext;
  logic [2*XLEN-1:0] mul_b_ext;
  logic [2*XLEN-1:0] mul_prod;
  logic [XLEN-1:0]   mul_result;

  assign mul_a_signed = (bus.Funct3E[1:0] != 2'b11);   // MULH, MULHSU
  assign mul_b_signed = (bus.Funct3E[1:0] == 2'b01);   // MULH only
  assign mul_a_ext    = {{XLEN{mul_a_signed & src_a[XLEN-1]}}, src_a};
  assign mul_b_ext    = {{XLEN{mul_b_signed & src_b[XLEN-1]}}, src_b};
  assign mul_prod     = mul_a_ext * mul_b_ext;
  assign mul_result   = (bus.Funct3E[1:0] == 2'b00) ? mul_prod[XLEN-1:0]
                                                    : mul_prod[2*XLEN-1:XLEN];

  // ------------------------------------------------------------- divider
  div_state_t      state_reg,   state_next;
  logic [4:0]      count_reg,   count_next;
  logic [XLEN-1:0] dq_reg,      dq_next;       // dividend out, quotient in
  logic [XLEN-1:0] rem_reg,     rem_next;
  logic [XLEN-1:0] divisor_reg, divisor_next;
  logic            neg_q_reg,   neg_q_next;
  logic            neg_r_reg,   neg_r_next;
  logic            op_rem_reg,  op_rem_next;
  logic            stall;

  logic            div_op;
  logic            div_signed;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            div_by_zero;
  logic            div_ovf;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] div_result;

  assign div_op      = bus.MulDivE & bus.Funct3E[2];
  assign div_signed  = ~bus.Funct3E[0];
  assign a_neg       = div_signed & src_a[XLEN-1];
  assign b_neg       = div_signed & src_b[XLEN-1];
  assign abs_a       = a_neg ? (~src_a + 1'b1) : src_a;
  assign abs_b       = b_neg ? (~src_b + 1'b1) : src_b;
  assign div_by_zero = (src_b == '0);
  assign div_ovf     = div_signed && (src_a == {1'b1, {(XLEN-1){1'b0}}})
                                  && (src_b == {XLEN{1'b1}});

  // Trial subtraction of the shifted partial remainder. The partial
  // remainder is always smaller than the divisor, so a clear MSB of the
  // XLEN+1-bit difference means the subtraction fits.
  assign diff = {rem_reg, dq_reg[XLEN-1]} - {1'b0, divisor_reg};

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    dq_next      = dq_reg;
    rem_next     = rem_reg;
    divisor_next = divisor_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    op_rem_next  = op_rem_reg;
    stall        = 1'b0;

    case (state_reg)
      IDLE: begin
        if (div_op && !bus.FlushE) begin
          // The operands are latched here because ResultW and ALUResultM
          // can change while the stage is stalled.
          stall       = 1'b1;
          op_rem_next = bus.Funct3E[1];
          if (div_by_zero) begin
            dq_next    = {XLEN{1'b1}};
            rem_next   = src_a;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = DONE;
          end else if (div_ovf) begin
            dq_next    = {1'b1, {(XLEN-1){1'b0}}};
            rem_next   = '0;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            state_next = DONE;
          end else begin
            dq_next      = abs_a;
            rem_next     = '0;
            divisor_next = abs_b;
            neg_q_next   = a_neg ^ b_neg;
            neg_r_next   = a_neg;
            count_next   = 5'd0;
            state_next   = DIV;
          end
        end
      end

      DIV: begin
        stall      = 1'b1;
        count_next = count_reg + 5'd1;
        if (!diff[XLEN]) begin
          rem_next = diff[XLEN-1:0];
          dq_next  = {dq_reg[XLEN-2:0], 1'b1};
        end else begin
          rem_next = {rem_reg[XLEN-2:0], dq_reg[XLEN-1]};
          dq_next  = {dq_reg[XLEN-2:0], 1'b0};
        end
        if (count_reg == 5'd31) begin
          state_next = DONE;
        end
        if (bus.FlushE) begin
          state_next = IDLE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      dq_reg      <= '0;
      rem_reg     <= '0;
      divisor_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      op_rem_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      dq_reg      <= dq_next;
      rem_reg     <= rem_next;
      divisor_reg <= divisor_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      op_rem_reg  <= op_rem_next;
    end
  end

  // Apply the sign correction to the unsigned magnitudes. The special cases
  // load their final values with both sign flags clear.
  assign div_result = op_rem_reg ? (neg_r_reg ? (~rem_reg + 1'b1) : rem_reg)
                                 : (neg_q_reg ? (~dq_reg  + 1'b1) : dq_reg);

  // ------------------------------------------------------ branch / jump
  logic            branch_taken;
  logic [XLEN-1:0] jalr_sum;

  always_comb begin
    branch_taken = 1'b0;
    case (bus.Funct3E)
      3'd0:    branch_taken = (src_a == fwd_b);
      3'd1:    branch_taken = (src_a != fwd_b);
      3'd4:    branch_taken = ($signed(src_a) <  $signed(fwd_b));
      3'd5:    branch_taken = ($signed(src_a) >= $signed(fwd_b));
      3'd6:    branch_taken = (src_a <  fwd_b);
      3'd7:    branch_taken = (src_a >= fwd_b);
      default: branch_taken = 1'b0;
    endcase
  end

  assign jalr_sum      = src_a + bus.ImmExtE;
  assign bus.PCTargetE = bus.JalrE ? {jalr_sum[XLEN-1:1], 1'b0}
                                   : (bus.PCE + bus.ImmExtE);
  assign bus.PCSrcE    = ~bus.FlushE & (bus.JumpE | (bus.BranchE & branch_taken));
  assign bus.StallE    = stall;

  // ------------------------------------------------------ EX/MEM register
  logic [XLEN-1:0] ex_result;

  // In DONE the divide instruction is still held in ID/EX. Its control
  // fields therefore travel with the divider result.
  assign ex_result = (state_reg == DONE) ? div_result :
                     bus.MulDivE         ? mul_result :
                                           alu_result;

  always_ff @(posedge clk) begin
    if (rst || stall || bus.FlushE) begin
      alu_result_m_reg <= '0;
      write_data_m_reg <= '0;
      pc_plus4_m_reg   <= '0;
      rd_m_reg         <= '0;
      reg_write_m_reg  <= '0;
      mem_write_m_reg  <= '0;
      result_src_m_reg <= '0;
    end else begin
      alu_result_m_reg <= ex_result;
      write_data_m_reg <= fwd_b;
      pc_plus4_m_reg   <= bus.PCPlus4E;
      rd_m_reg         <= bus.RDE;
      reg_write_m_reg  <= bus.RegWriteE;
      mem_write_m_reg  <= bus.MemWriteE;
      result_src_m_reg <= bus.ResultSrcE;
    end
  end

  assign bus.ALUResultM = alu_result_m_reg;
  assign bus.WriteDataM = write_data_m_reg;
  assign bus.PCPlus4M   = pc_plus4_m_reg;
  assign bus.RDM        = rd_m_reg;
  assign bus.RegWriteM  = reg_write_m_reg;
  assign bus.MemWriteM  = mem_write_m_reg;
  assign bus.ResultSrcM = result_src_m_reg;

endmodule

// File: tb/tb_execute_cycle.sv
// ---------------------------------------------------------------------------
// tb_execute_cycle
//   Self-checking bench for execute_cycle. Inputs change 1 ns after a rising
//   edge. Outputs are sampled 1 ns after an edge (registered outputs) or 1 ns
//   after the inputs change (combinational outputs). Expected values come
//   from plain-arithmetic reference functions.
// ---------------------------------------------------------------------------
module tb_execute_cycle;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  execute_cycle_if bus ();

  execute_cycle dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ------------------------------------------------------ reference model
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    sa = a;
    case (c)
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return (a < b) ? 32'd1 : 32'd0;
      4'd7:    return a << b[4:0];
      4'd8:    return a >> b[4:0];
      4'd9:    return sa >>> b[4:0];
      4'd10:   return b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3[1:0])
      2'd0:    begin p = ua * ub; return p[31:0];  end
      2'd1:    begin p = sa * sb; return p[63:32]; end
      2'd2:    begin p = sa * ub; return p[63:32]; end
      default: begin p = ua * ub; return p[63:32]; end
    endcase
  endfunction

  function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!f3[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return f3[1] ? r : q;
  endfunction

  function automatic bit ref_branch(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // ------------------------------------------------------------ stimulus
  task automatic set_nop();
    bus.RD1E = '0;        bus.RD2E = '0;        bus.ImmExtE = '0;
    bus.PCE = '0;         bus.PCPlus4E = '0;    bus.RDE = '0;
    bus.RegWriteE = '0;   bus.MemWriteE = '0;   bus.ResultSrcE = '0;
    bus.ALUControlE = '0; bus.ALUSrcE = 1'b0;   bus.Funct3E = '0;
    bus.MulDivE = 1'b0;   bus.BranchE = 1'b0;   bus.JumpE = 1'b0;
    bus.JalrE = 1'b0;     bus.ForwardAE = '0;   bus.ForwardBE = '0;
    bus.ResultW = '0;     bus.FlushE = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_nop();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.ALUResultM !== 32'd0 || bus.RegWriteM !== 3'd0 || bus.RDM !== 5'd0 ||
        bus.MemWriteM !== 2'd0 || bus.StallE !== 1'b0) begin
      failures++;
      $display("FAIL reset: got res=%h rw=%0d rd=%0d mw=%0d stall=%b exp all 0",
               bus.ALUResultM, bus.RegWriteM, bus.RDM, bus.MemWriteM, bus.StallE);
    end
    rst = 1'b0;
    $display("txn reset done");
  endtask

  task automatic test_add();
    set_nop();
    bus.RD1E = 32'd7; bus.ImmExtE = 32'hFFFF_FFFD; bus.ALUSrcE = 1'b1;
    bus.RDE = 5'd5; bus.RegWriteE = 3'd1;
    @(posedge clk); #1;
    checks++;
    if (bus.ALUResultM !== 32'd4 || bus.RDM !== 5'd5 || bus.RegWriteM !== 3'd1) begin
      failures++;
      $display("FAIL add_imm: got res=%h rd=%0d rw=%0d exp res=4 rd=5 rw=1",
               bus.ALUResultM, bus.RDM, bus.RegWriteM);
    end
    $display("txn ADD 7+(-3) -> %h", bus.ALUResultM);
  endtask

  task automatic test_branch_jump();
    set_nop();
    bus.RD1E = 32'd9; bus.RD2E = 32'd9; bus.BranchE = 1'b1; bus.Funct3E = 3'd0;
    bus.PCE = 32'h100; bus.ImmExtE = 32'h20;
    #1;
    checks++;
    if (bus.PCSrcE !== 1'b1 || bus.PCTargetE !== 32'h120) begin
      failures++;
      $display("FAIL beq_taken: got src=%b tgt=%h exp src=1 tgt=120", bus.PCSrcE, bus.PCTargetE);
    end
    $display("txn BEQ 9==9 -> PCSrcE=%b PCTargetE=%h", bus.PCSrcE, bus.PCTargetE);
    bus.Funct3E = 3'd1;
    #1;
    checks++;
    if (bus.PCSrcE !== 1'b0) begin
      failures++;
      $display("FAIL bne_not_taken: got src=%b exp src=0", bus.PCSrcE);
    end
    $display("txn BNE 9!=9 -> PCSrcE=%b", bus.PCSrcE);
    set_nop();
    bus.JumpE = 1'b1; bus.JalrE = 1'b1; bus.RD1E = 32'h203; bus.ImmExtE = 32'd0;
    #1;
    checks++;
    if (bus.PCSrcE !== 1'b1 || bus.PCTargetE !== 32'h202) begin
      failures++;
      $display("FAIL jalr: got src=%b tgt=%h exp src=1 tgt=202", bus.PCSrcE, bus.PCTargetE);
    end
    $display("txn JALR 0x203+0 -> PCTargetE=%h", bus.PCTargetE);
    bus.FlushE = 1'b1;
    #1;
    checks++;
    if (bus.PCSrcE !== 1'b0) begin
      failures++;
      $display("FAIL flush_jump: got src=%b exp src=0", bus.PCSrcE);
    end
    $display("txn flushed JALR -> PCSrcE=%b", bus.PCSrcE);
    @(posedge clk); #1;
    set_nop();
  endtask

  task automatic test_mul_directed();
    set_nop();
    bus.MulDivE = 1'b1; bus.Funct3E = 3'd1; bus.RDE = 5'd6; bus.RegWriteE = 3'd1;
    bus.RD1E = 32'h8000_0000; bus.RD2E = 32'h8000_0000;
    @(posedge clk); #1;
    checks++;
    if (bus.ALUResultM !== 32'h4000_0000) begin
      failures++;
      $display("FAIL mulh: got=%h exp=40000000", bus.ALUResultM);
    end
    $display("txn MULH 80000000*80000000 -> %h", bus.ALUResultM);
    bus.Funct3E = 3'd3; bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    checks++;
    if (bus.ALUResultM !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL mulhu: got=%h exp=fffffffe", bus.ALUResultM);
    end
    $display("txn MULHU ffffffff^2 -> %h", bus.ALUResultM);
    set_nop();
  endtask

  task automatic test_random_alu(input int n);
    logic [31:0] rd1, rd2, imm, pc, rw, a, wd, b, exp_res, exp_tgt, prev_m;
    logic [3:0]  ctrl;
    logic [2:0]  f3, regw;
    logic [1:0]  fa, fb, memw, rsrc;
    logic [4:0]  rd;
    bit          alusrc, md, fl, br, jmp, jalr, exp_src;
    prev_m = '0;
    for (int i = 0; i < n; i++) begin
      rd1 = $urandom; rd2 = $urandom; imm = $urandom; pc = $urandom; rw = $urandom;
      ctrl = 4'($urandom_range(0, 15)); alusrc = 1'($urandom_range(0, 1));
      md = ($urandom_range(0, 3) == 0); f3 = 3'($urandom_range(0, 7));
      if (md) f3[2] = 1'b0;
      fa = 2'($urandom_range(0, 3)); fb = 2'($urandom_range(0, 3));
      if (i == 0) begin
        if (fa == 2'b10) fa = 2'b00;
        if (fb == 2'b10) fb = 2'b00;
      end
      if ($urandom_range(0, 3) == 0) rd2 = rd1;
      fl = ($urandom_range(0, 9) == 0); br = 1'($urandom_range(0, 1));
      jmp = ($urandom_range(0, 3) == 0); jalr = 1'($urandom_range(0, 1));
      rd = 5'($urandom); regw = 3'($urandom); memw = 2'($urandom); rsrc = 2'($urandom);

      bus.RD1E = rd1; bus.RD2E = rd2; bus.ImmExtE = imm; bus.PCE = pc;
      bus.PCPlus4E = pc + 32'd4; bus.RDE = rd; bus.RegWriteE = regw;
      bus.MemWriteE = memw; bus.ResultSrcE = rsrc; bus.ALUControlE = ctrl;
      bus.ALUSrcE = alusrc; bus.Funct3E = f3; bus.MulDivE = md; bus.BranchE = br;
      bus.JumpE = jmp; bus.JalrE = jalr; bus.ForwardAE = fa; bus.ForwardBE = fb;
      bus.ResultW = rw; bus.FlushE = fl;

      a  = (fa == 2'b01) ? rw : (fa == 2'b10) ? prev_m : rd1;
      wd = (fb == 2'b01) ? rw : (fb == 2'b10) ? prev_m : rd2;
      b  = alusrc ? imm : wd;
      exp_res = md ? ref_mul(f3, a, b) : ref_alu(ctrl, a, b);
      exp_src = !fl && (jmp || (br && ref_branch(f3, a, wd)));
      exp_tgt = jalr ? ((a + imm) & ~32'd1) : (pc + imm);

      #1;
      checks++;
      if (bus.PCSrcE !== exp_src || bus.PCTargetE !== exp_tgt || bus.StallE !== 1'b0) begin
        failures++;
        $display("FAIL rand_redirect[%0d]: got src=%b tgt=%h stall=%b exp src=%b tgt=%h stall=0",
                 i, bus.PCSrcE, bus.PCTargetE, bus.StallE, exp_src, exp_tgt);
      end
      @(posedge clk); #1;
      checks++;
      if (fl) begin
        if (bus.ALUResultM !== 32'd0 || bus.RegWriteM !== 3'd0 || bus.MemWriteM !== 2'd0 ||
            bus.RDM !== 5'd0) begin
          failures++;
          $display("FAIL rand_flush[%0d]: got res=%h rw=%0d mw=%0d rd=%0d exp bubble",
                   i, bus.ALUResultM, bus.RegWriteM, bus.MemWriteM, bus.RDM);
        end
        prev_m = '0;
      end else begin
        if (bus.ALUResultM !== exp_res || bus.WriteDataM !== wd || bus.RDM !== rd ||
            bus.RegWriteM !== regw || bus.MemWriteM !== memw || bus.ResultSrcM !== rsrc ||
            bus.PCPlus4M !== pc + 32'd4) begin
          failures++;
          $display("FAIL rand_exmem[%0d]: got res=%h wd=%h rd=%0d rw=%0d exp res=%h wd=%h rd=%0d rw=%0d",
                   i, bus.ALUResultM, bus.WriteDataM, bus.RDM, bus.RegWriteM, exp_res, wd, rd, regw);
        end
        prev_m = exp_res;
      end
      $display("txn rand %0d ctrl=%0d md=%b f3=%0d fa=%0d fb=%0d flush=%b res=%h",
               i, ctrl, md, f3, fa, fb, fl, bus.ALUResultM);
    end
    set_nop();
  endtask

  // One divide: acceptance, stall length, bubbles while stalled, then commit.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                        input logic [31:0] exp_res, input int exp_stall, input bit use_fwd);
    int         n;
    logic [4:0] rd;
    rd = 5'($urandom_range(1, 31));
    set_nop();
    bus.MulDivE = 1'b1; bus.Funct3E = f3; bus.RDE = rd; bus.RegWriteE = 3'd1;
    bus.RD2E = b;
    if (use_fwd) begin
      bus.ForwardAE = 2'b01; bus.ResultW = a; bus.RD1E = $urandom;
    end else begin
      bus.RD1E = a;
    end
    #1;
    n = 0;
    while (bus.StallE === 1'b1 && n < 60) begin
      n++;
      @(posedge clk); #1;
      bus.ResultW = $urandom;
      checks++;
      if (bus.RegWriteM !== 3'd0 || bus.ALUResultM !== 32'd0 || bus.RDM !== 5'd0) begin
        failures++;
        $display("FAIL div_bubble: got res=%h rw=%0d rd=%0d exp bubble",
                 bus.ALUResultM, bus.RegWriteM, bus.RDM);
      end
    end
    checks++;
    if (n !== exp_stall) begin
      failures++;
      $display("FAIL div_stall_len: got=%0d exp=%0d", n, exp_stall);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.ALUResultM !== exp_res || bus.RegWriteM !== 3'd1 || bus.RDM !== rd) begin
      failures++;
      $display("FAIL div_result f3=%0d a=%h b=%h: got res=%h rw=%0d rd=%0d exp res=%h rw=1 rd=%0d",
               f3, a, b, bus.ALUResultM, bus.RegWriteM, bus.RDM, exp_res, rd);
    end
    set_nop();
    $display("txn div f3=%0d a=%h b=%h stall=%0d res=%h", f3, a, b, n, bus.ALUResultM);
  endtask

  task automatic test_div_directed();
    do_div(32'hFFFF_FFF9, 32'd2,         3'd4, 32'hFFFF_FFFD, 33, 1'b0);
    do_div(32'hFFFF_FFF9, 32'd2,         3'd6, 32'hFFFF_FFFF, 33, 1'b1);
    do_div(32'd12345,     32'd0,         3'd5, 32'hFFFF_FFFF, 1,  1'b0);
    do_div(32'hFFFF_FFF9, 32'd0,         3'd4, 32'hFFFF_FFFF, 1,  1'b0);
    do_div(32'd12345,     32'd0,         3'd7, 32'd12345,     1,  1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 32'h8000_0000, 1,  1'b0);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 32'd0,         1,  1'b0);
    do_div(32'd100,       32'hFFFF_FFF9, 3'd6, 32'd2,         33, 1'b0);
    do_div(32'hFFFF_FFFF, 32'd7,         3'd5, 32'h2492_4924, 33, 1'b0);
  endtask

  task automatic test_div_random(input int n);
    logic [31:0] a, b;
    logic [2:0]  f3;
    int          st;
    for (int i = 0; i < n; i++) begin
      a  = $urandom; b = $urandom;
      f3 = 3'($urandom_range(4, 7));
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = b >> 20;
        2:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      st = (b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      do_div(a, b, f3, ref_div(f3, a, b), st, 1'($urandom_range(0, 1)));
    end
  endtask

  // Start a divide, abort it at cycle 10 by flush or reset, and confirm that
  // nothing commits afterwards. The follow-on instruction writes a marker.
  task automatic test_abort_div(input bit by_reset);
    set_nop();
    bus.MulDivE = 1'b1; bus.Funct3E = 3'd4; bus.RD1E = 32'hFFFF_FFF9; bus.RD2E = 32'd2;
    bus.RDE = 5'd9; bus.RegWriteE = 3'd1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (bus.StallE !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_stall: got=%b exp=1", bus.StallE);
    end
    if (by_reset) rst = 1'b1;
    else          bus.FlushE = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_nop();
    bus.ALUControlE = 4'd10; bus.ALUSrcE = 1'b1; bus.ImmExtE = 32'h5A5A_1234;
    #1;
    checks++;
    if (bus.StallE !== 1'b0 || bus.RegWriteM !== 3'd0 || bus.ALUResultM !== 32'd0) begin
      failures++;
      $display("FAIL abort_next: got stall=%b rw=%0d res=%h exp stall=0 rw=0 res=0",
               bus.StallE, bus.RegWriteM, bus.ALUResultM);
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.StallE !== 1'b0 || bus.RegWriteM !== 3'd0 || bus.ALUResultM !== 32'h5A5A_1234) begin
        failures++;
        $display("FAIL abort_after[%0d]: got stall=%b rw=%0d res=%h exp stall=0 rw=0 res=5a5a1234",
                 i, bus.StallE, bus.RegWriteM, bus.ALUResultM);
      end
    end
    set_nop();
    $display("txn divide aborted by %s", by_reset ? "reset" : "flush");
  endtask

  task automatic test_back_to_back();
    do_div(32'hFFFF_FFEC, 32'd3, 3'd4, 32'hFFFF_FFFA, 33, 1'b0);
    bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b10; bus.ALUSrcE = 1'b1;
    bus.ImmExtE = 32'd1; bus.RDE = 5'd3; bus.RegWriteE = 3'd1;
    @(posedge clk); #1;
    checks++;
    if (bus.ALUResultM !== 32'hFFFF_FFFB || bus.WriteDataM !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL fwd_after_div: got res=%h wd=%h exp res=fffffffb wd=fffffffa",
               bus.ALUResultM, bus.WriteDataM);
    end
    $display("txn ADD fwd(div)+1 -> %h", bus.ALUResultM);
    set_nop();
  endtask

  initial begin
    rst = 1'b1;
    set_nop();
    test_reset();
    test_add();
    test_branch_jump();
    test_mul_directed();
    test_random_alu(200);
    test_div_directed();
    test_div_random(16);
    test_abort_div(1'b0);
    test_abort_div(1'b1);
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
